// File: rtl/var_state_loader.sv
// var_state_loader: bin load/unload engine moving packed variable states between bin memory and the cell array.
// Optional VAR_STATE_LOAD_CHECK_EN scrubs conflict-marked words on load and raises a sticky err_o.
module var_state_loader #(
    parameter int NUM_VARS         = 8,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_ADDR       = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_start_i,
    input  logic                                 store_start_i,
    input  logic [WIDTH_ADDR-1:0]                base_addr_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic                                 mem_rd_en_o,
    output logic [WIDTH_ADDR-1:0]                mem_rd_addr_o,
    input  logic [WIDTH_VAR_STATES-1:0]          mem_rd_data_i,
    input  logic                                 mem_rd_valid_i,
    output logic                                 mem_wr_en_o,
    output logic [WIDTH_ADDR-1:0]                mem_wr_addr_o,
    output logic [WIDTH_VAR_STATES-1:0]          mem_wr_data_o,
    input  logic                                 mem_wr_ready_i,
    output logic [NUM_VARS-1:0]                  wr_states_o,
    output logic [WIDTH_VAR_STATES-1:0]          vars_states_o,
    input  logic [NUM_VARS*WIDTH_VAR_STATES-1:0] vars_states_i
);
    localparam int IW = NUM_VARS > 1 ? $clog2(NUM_VARS) : 1;
    localparam int W  = WIDTH_VAR_STATES;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_CELL, SNAP, WR_MEM, DONE} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [WIDTH_ADDR-1:0]     base_q, base_d;
    logic [W-1:0]              data_q, data_d;
    logic [NUM_VARS*W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]              cell_word;
    logic                      last;
    logic [WIDTH_ADDR-1:0]     addr;

    assign last = idx_q == IW'(NUM_VARS - 1);
    assign addr = base_q + WIDTH_ADDR'(idx_q);

`ifdef VAR_STATE_LOAD_CHECK_EN
    logic err_q, err_d, conflict;
    // value[2:1]==11 marks a conflict, which must never land in a cell
    assign conflict  = data_q[W-1 -: 2] == 2'b11;
    assign cell_word = conflict ? {3'b000, data_q[W-4:0]} : data_q;
    assign err_d     = err_q | (state_q == WR_CELL && conflict);
    assign err_o     = err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign cell_word = data_q;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            base_q   <= '0;
            data_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: if (store_start_i || load_start_i) begin
                base_d  = base_addr_i;
                idx_d   = '0;
                state_d = store_start_i ? SNAP : RD_REQ;
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: if (mem_rd_valid_i) begin
                data_d  = mem_rd_data_i;
                state_d = WR_CELL;
            end
            WR_CELL: begin
                state_d = last ? DONE : RD_REQ;
                idx_d   = last ? idx_q : idx_q + IW'(1);
            end
            SNAP: begin
                shadow_d = vars_states_i;
                state_d  = WR_MEM;
            end
            WR_MEM: if (mem_wr_ready_i) begin
                state_d = last ? DONE : WR_MEM;
                idx_d   = last ? idx_q : idx_q + IW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = state_q != IDLE;
        done_o        = state_q == DONE;
        mem_rd_en_o   = state_q == RD_REQ;
        mem_rd_addr_o = addr;
        mem_wr_en_o   = state_q == WR_MEM;
        mem_wr_addr_o = addr;
        mem_wr_data_o = shadow_q[idx_q*W +: W];
        wr_states_o   = state_q == WR_CELL ? {{(NUM_VARS-1){1'b0}}, 1'b1} << idx_q : '0;
        vars_states_o = state_q == WR_CELL ? cell_word : data_q;
    end
endmodule

// File: tb/tb_var_state_loader.sv
// tb_var_state_loader: scoreboard bench for var_state_loader; honours VAR_STATE_LOAD_CHECK_EN when defined.
module tb_var_state_loader;
    logic         clk = 0;
    logic         rst = 1;
    logic         load_start_i = 0, store_start_i = 0;
    logic [11:0]  base_addr_i = 0;
    logic         busy_o, done_o, err_o;
    logic         mem_rd_en_o, mem_wr_en_o;
    logic [11:0]  mem_rd_addr_o, mem_wr_addr_o;
    logic [18:0]  mem_rd_data_i = 0, mem_wr_data_o, vars_states_o;
    logic         mem_rd_valid_i = 0, mem_wr_ready_i = 1;
    logic [7:0]   wr_states_o;
    logic [151:0] vars_states_i = 0;

    int tests = 0, fails = 0;
    logic [11:0] rd_q[$];
    logic [26:0] cell_q[$];
    logic [30:0] wr_q[$];
    logic [18:0] mem [4096];
    logic        hold = 0, force_valid = 0, pend = 0;
    logic [18:0] force_data = 0, pend_data = 0;
    logic [11:0] stall_addr = 12'hfff;
    int          stall_left = 0;

    var_state_loader dut (
        .clk(clk), .rst(rst), .load_start_i(load_start_i), .store_start_i(store_start_i),
        .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .mem_rd_valid_i(mem_rd_valid_i), .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_ready_i(mem_wr_ready_i), .wr_states_o(wr_states_o),
        .vars_states_o(vars_states_o), .vars_states_i(vars_states_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory: read data one cycle after the request, writes accepted unless a stall is armed
    initial forever begin
        @(negedge clk);
        mem_rd_valid_i = hold ? force_valid : pend;
        mem_rd_data_i  = hold ? force_data : pend_data;
        pend           = mem_rd_en_o;
        pend_data      = mem[mem_rd_addr_o];
        if (mem_wr_en_o && mem_wr_addr_o == stall_addr && stall_left > 0) begin
            mem_wr_ready_i = 0;
            stall_left--;
        end else mem_wr_ready_i = 1;
    end

    initial forever begin
        logic [26:0] c;
        logic [30:0] w;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (mem_rd_en_o) begin
                if (rd_q.size() == 0) chk("unexpected_rd", 1, 0);
                else chk("rd_addr", mem_rd_addr_o, rd_q.pop_front());
            end
            if (wr_states_o != 0) begin
                if (cell_q.size() == 0) chk("unexpected_cell", 1, 0);
                else begin
                    c = cell_q.pop_front();
                    chk("cell_strobe", wr_states_o, c[26:19]);
                    chk("cell_word", vars_states_o, c[18:0]);
                end
            end
            if (mem_wr_en_o) begin
                if (wr_q.size() == 0) chk("unexpected_wr", 1, 0);
                else begin
                    w = mem_wr_ready_i ? wr_q.pop_front() : wr_q[0];
                    chk(mem_wr_ready_i ? "wr_addr" : "stall_addr", mem_wr_addr_o, w[30:19]);
                    chk(mem_wr_ready_i ? "wr_data" : "stall_data", mem_wr_data_o, w[18:0]);
                end
            end
        end
    end

    task automatic push_load(input logic [11:0] base);
        logic [11:0] a;
        logic [18:0] e;
        for (int i = 0; i < 8; i++) begin
            a = base + 12'(i);
            e = mem[a];
`ifdef VAR_STATE_LOAD_CHECK_EN
            if (e[18:17] == 2'b11) e[18:16] = 3'b000;
`endif
            rd_q.push_back(a);
            cell_q.push_back({8'(1 << i), e});
        end
    endtask

    task automatic push_store(input logic [11:0] base);
        for (int i = 0; i < 8; i++) wr_q.push_back({12'(base + 12'(i)), vars_states_i[i*19 +: 19]});
    endtask

    task automatic set_cells(input logic [2:0] v, input int lvl0);
        for (int i = 0; i < 8; i++) vars_states_i[i*19 +: 19] = {v, 16'(lvl0 + i)};
    endtask

    task automatic start(input logic ld, input logic st, input logic [11:0] base);
        @(negedge clk);
        load_start_i = ld; store_start_i = st; base_addr_i = base;
        @(negedge clk);
        load_start_i = 0; store_start_i = 0;
    endtask

    // n0 = cycle index already reached since the start cycle; exp = 0 skips the latency check
    task automatic wait_done(input string name, input int n0, input int exp);
        int n = n0;
        while (!done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, done_o, 1);
        if (exp > 0) chk({name, "_latency"}, n, exp);
        @(negedge clk);
        chk({name, "_busy_low"}, busy_o, 0);
        chk({name, "_rd_q_empty"}, rd_q.size(), 0);
        chk({name, "_cell_q_empty"}, cell_q.size(), 0);
        chk({name, "_wr_q_empty"}, wr_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'(i);
        repeat (2) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_outs", {done_o, err_o, mem_rd_en_o, mem_wr_en_o, wr_states_o}, 0);
        rst = 0;

        for (int i = 0; i < 8; i++) mem[12'h100 + i] = {3'b010, 16'(i)};
        push_load(12'h100);
        start(1, 0, 12'h100);
        wait_done("load", 1, 25);

        set_cells(3'b001, 5);
        push_store(12'h200);
        stall_addr = 12'h203; stall_left = 2;
        start(0, 1, 12'h200);
        @(negedge clk);
        set_cells(3'b111, 100);
        wait_done("store", 2, 12);

        set_cells(3'b100, 32);
        push_store(12'h600);
        start(1, 1, 12'h600);
        repeat (3) @(negedge clk);
        load_start_i = 1; base_addr_i = 12'h700;
        @(negedge clk);
        load_start_i = 0;
        wait_done("both", 5, 0);
        repeat (3) @(negedge clk);
        chk("both_stays_idle", busy_o, 0);

        for (int i = 0; i < 8; i++) mem[12'(12'hffe + 12'(i))] = {3'b001, 16'(16'h50 + i)};
        push_load(12'hffe);
        start(1, 0, 12'hffe);
        wait_done("wrap", 1, 25);
        chk("err_clear_before_conflict", err_o, 0);

        for (int i = 0; i < 8; i++) mem[12'h500 + i] = {3'b001, 16'(i)};
        mem[12'h502] = {3'b110, 16'd7};
        push_load(12'h500);
        start(1, 0, 12'h500);
        wait_done("conflict", 1, 25);
`ifdef VAR_STATE_LOAD_CHECK_EN
        chk("conflict_err", err_o, 1);
`else
        chk("conflict_err", err_o, 0);
`endif

        hold = 1;
        rd_q.push_back(12'h300);
        start(1, 0, 12'h300);
        @(negedge clk);
        rst = 1; force_valid = 1; force_data = {3'b010, 16'h1234};
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rd", {mem_rd_en_o, mem_rd_addr_o}, 0);
        chk("rst_wr", {mem_wr_en_o, mem_wr_addr_o}, 0);
        chk("rst_wr_data", mem_wr_data_o, 0);
        chk("rst_strobe", wr_states_o, 0);
        chk("rst_word", vars_states_o, 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        force_valid = 0;
        repeat (3) @(negedge clk);
        hold = 0;
        chk("post_rst_idle", busy_o, 0);
        for (int i = 0; i < 8; i++) mem[12'h400 + i] = {3'b011, 16'(16'h900 + i)};
        push_load(12'h400);
        start(1, 0, 12'h400);
        wait_done("restart", 1, 25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
